// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared types for the trap controller and the CSR-side interface.
//   exc_cause_t  - mcause exception codes driven into the CSR file
//   trap_state_t - trap controller FSM encoding (2 bits)
package trap_ctrl_pkg;

  typedef enum logic [4:0] {
    EXC_INSTR_MISALIGNED = 5'd0,
    EXC_ILLEGAL_INSTR    = 5'd2,
    EXC_BREAKPOINT       = 5'd3,
    EXC_LOAD_MISALIGNED  = 5'd4,
    EXC_STORE_MISALIGNED = 5'd6,
    EXC_ECALL_M          = 5'd11
  } exc_cause_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP_REDIR = 2'd1,
    MRET_REDIR = 2'd2
  } trap_state_t;

  localparam int unsigned CAUSE_W = 5;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: trap-handling link between the trap controller and the CSR file.
//   save_pc_id_o      - write ID PC into mepc
//   save_pc_ex_o      - write EX PC into mepc
//   exception_cause_o - mcause code (0 when no save strobe)
//   mret_o            - one-cycle MRET commit pulse
//   mtvec_i           - trap vector from CSR (direct mode)
//   mepc_i            - return address from CSR (next-value form)
// Signalling: every strobe is a single-cycle, fire-and-forget pulse with no
// back-pressure; the CSR file must accept it in the cycle it is asserted.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic        save_pc_id_o;
  logic        save_pc_ex_o;
  exc_cause_t  exception_cause_o;
  logic        mret_o;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;

  modport master (
    output save_pc_id_o, save_pc_ex_o, exception_cause_o, mret_o,
    input  mtvec_i, mepc_i
  );

  modport slave (
    input  save_pc_id_o, save_pc_ex_o, exception_cause_o, mret_o,
    output mtvec_i, mepc_i
  );
endinterface

// File: rtl/trap_ctrl_exc_prio_enc.sv
// exc_prio_enc: combinational priority encoder for exception requests.
//   req_i   - request vector, bit 0 has the highest priority
//   valid_o - any request present
//   cause_o - cause of the winning request (0 when none)
// CAUSES packs one 5-bit cause per request bit, bit i at [i*5 +: 5].
module exc_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned       N      = 2,
  parameter logic [N*5-1:0]    CAUSES = '0
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output exc_cause_t   cause_o
);

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    valid_o = 1'b0;
    cause_o = EXC_INSTR_MISALIGNED;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        cause_o = exc_cause_t'(CAUSES[i*CAUSE_W +: CAUSE_W]);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/MRET initiator for the CSR file.
//   clk_i, rst_n_i       - clock, asynchronous active-low reset
//   id_*                 - ID-stage exception / MRET requests
//   ex_*                 - EX-stage exception requests and branch target
//   csr                  - CSR link (save strobes, cause, mret, mtvec, mepc)
//   flush_o              - kill IF/ID/EX this cycle
//   pc_set_o/pc_target_o - fetch redirect strobe and address
//   busy_o               - FSM not in IDLE
//   state_o              - FSM state for observation
// A request in cycle N raises save/flush in N, redirects in N+1, and new
// requests are accepted again from N+2.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ISA_C = 0,
  parameter int ISA_M = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        id_valid_i,
  input  logic        id_stall_i,
  input  logic        id_instr_misaligned_i,
  input  logic        id_illegal_i,
  input  logic        id_ebreak_i,
  input  logic        id_ecall_i,
  input  logic        id_mret_i,
  input  logic        ex_valid_i,
  input  logic        ex_load_misaligned_i,
  input  logic        ex_store_misaligned_i,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_branch_target_i,
  trap_ctrl_if.master csr,
  output logic        flush_o,
  output logic        pc_set_o,
  output logic [31:0] pc_target_o,
  output logic        busy_o,
  output trap_state_t state_o
);

  trap_state_t state_q, state_d;

  logic       id_go;
  logic       br_misaligned;
  logic       ex_trap, id_trap;
  exc_cause_t ex_cause, id_cause;
  logic       unused_bits;

  // Only the alignment bits of the target matter here; ISA_M has no effect.
  assign unused_bits = ^ex_branch_target_i[31:2] ^ (ISA_M != 0);

  assign id_go         = id_valid_i && !id_stall_i;
  assign br_misaligned = ex_branch_taken_i &&
                         ((ISA_C != 0) ? ex_branch_target_i[0]
                                       : (ex_branch_target_i[1:0] != 2'b00));

  exc_prio_enc #(
    .N      (3),
    .CAUSES ({5'd6, 5'd4, 5'd0})
  ) u_ex_enc (
    .req_i   ({ex_store_misaligned_i, ex_load_misaligned_i, br_misaligned} & {3{ex_valid_i}}),
    .valid_o (ex_trap),
    .cause_o (ex_cause)
  );

  exc_prio_enc #(
    .N      (4),
    .CAUSES ({5'd11, 5'd3, 5'd2, 5'd0})
  ) u_id_enc (
    .req_i   ({id_ecall_i, id_ebreak_i, id_illegal_i, id_instr_misaligned_i} & {4{id_go}}),
    .valid_o (id_trap),
    .cause_o (id_cause)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Outputs are forced low while reset is held so nothing leaks out of a
  // reset that lands mid-redirect.
  always_comb begin
    state_d               = state_q;
    csr.save_pc_id_o      = 1'b0;
    csr.save_pc_ex_o      = 1'b0;
    csr.exception_cause_o = EXC_INSTR_MISALIGNED;
    csr.mret_o            = 1'b0;
    flush_o               = 1'b0;
    pc_set_o              = 1'b0;
    pc_target_o           = 32'h0;
    if (rst_n_i) begin
      case (state_q)
        IDLE: begin
          // EX is the older instruction, so it beats ID; ID traps beat MRET.
          if (ex_trap) begin
            csr.save_pc_ex_o      = 1'b1;
            csr.exception_cause_o = ex_cause;
            flush_o               = 1'b1;
            state_d               = TRAP_REDIR;
          end else if (id_trap) begin
            csr.save_pc_id_o      = 1'b1;
            csr.exception_cause_o = id_cause;
            flush_o               = 1'b1;
            state_d               = TRAP_REDIR;
          end else if (id_go && id_mret_i) begin
            csr.mret_o = 1'b1;
            flush_o    = 1'b1;
            state_d    = MRET_REDIR;
          end
        end
        TRAP_REDIR: begin
          pc_set_o    = 1'b1;
          pc_target_o = csr.mtvec_i;
          flush_o     = 1'b1;
          state_d     = IDLE;
        end
        MRET_REDIR: begin
          pc_set_o    = 1'b1;
          pc_target_o = csr.mepc_i;
          flush_o     = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o  = rst_n_i && (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        id_valid_i, id_stall_i, id_instr_misaligned_i, id_illegal_i;
  logic        id_ebreak_i, id_ecall_i, id_mret_i;
  logic        ex_valid_i, ex_load_misaligned_i, ex_store_misaligned_i;
  logic        ex_branch_taken_i;
  logic [31:0] ex_branch_target_i;

  logic        flush0, pc_set0, busy0;
  logic [31:0] pc_target0;
  trap_state_t state0;
  logic        flush1, pc_set1, busy1;
  logic [31:0] pc_target1;
  trap_state_t state1;

  trap_ctrl_if csr0 ();
  trap_ctrl_if csr1 ();

  int checks = 0;
  int errors = 0;

  // expected bundle: {save_id, save_ex, cause[4:0], flush, pc_set, target[31:0], mret, busy}
  logic [42:0] exp_q[$];
  logic [42:0] exp_c_q[$];
  logic [42:0] obs0, obs1;
  localparam logic [42:0] Z = 43'd0;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.ISA_C(0), .ISA_M(0)) dut (
    .clk_i, .rst_n_i, .id_valid_i, .id_stall_i, .id_instr_misaligned_i,
    .id_illegal_i, .id_ebreak_i, .id_ecall_i, .id_mret_i, .ex_valid_i,
    .ex_load_misaligned_i, .ex_store_misaligned_i, .ex_branch_taken_i,
    .ex_branch_target_i, .csr(csr0), .flush_o(flush0), .pc_set_o(pc_set0),
    .pc_target_o(pc_target0), .busy_o(busy0), .state_o(state0)
  );

  trap_ctrl #(.ISA_C(1), .ISA_M(0)) dut_c (
    .clk_i, .rst_n_i, .id_valid_i, .id_stall_i, .id_instr_misaligned_i,
    .id_illegal_i, .id_ebreak_i, .id_ecall_i, .id_mret_i, .ex_valid_i,
    .ex_load_misaligned_i, .ex_store_misaligned_i, .ex_branch_taken_i,
    .ex_branch_target_i, .csr(csr1), .flush_o(flush1), .pc_set_o(pc_set1),
    .pc_target_o(pc_target1), .busy_o(busy1), .state_o(state1)
  );

  assign obs0 = {csr0.save_pc_id_o, csr0.save_pc_ex_o, csr0.exception_cause_o,
                 flush0, pc_set0, pc_target0, csr0.mret_o, busy0};
  assign obs1 = {csr1.save_pc_id_o, csr1.save_pc_ex_o, csr1.exception_cause_o,
                 flush1, pc_set1, pc_target1, csr1.mret_o, busy1};

  function automatic logic [42:0] mk(input logic sid, input logic sex,
                                     input logic [4:0] cause, input logic fl,
                                     input logic ps, input logic [31:0] tgt,
                                     input logic mr, input logic bz);
    return {sid, sex, cause, fl, ps, tgt, mr, bz};
  endfunction

  task automatic clear_in();
    id_valid_i = 0; id_stall_i = 0; id_instr_misaligned_i = 0; id_illegal_i = 0;
    id_ebreak_i = 0; id_ecall_i = 0; id_mret_i = 0; ex_valid_i = 0;
    ex_load_misaligned_i = 0; ex_store_misaligned_i = 0; ex_branch_taken_i = 0;
    ex_branch_target_i = 32'h0;
  endtask

  task automatic push2(input logic [42:0] e0, input logic [42:0] e1);
    exp_q.push_back(e0);
    exp_c_q.push_back(e1);
  endtask

  // Compare both DUTs against the head of their queues, then advance a cycle.
  task automatic cyc(input string tag);
    logic [42:0] e0, e1;
    #1;
    checks++;
    assert (exp_q.size() > 0 && exp_c_q.size() > 0) else begin
      errors++; $error("FAIL %s_queue observed empty expected entry", tag);
    end
    if (exp_q.size() > 0 && exp_c_q.size() > 0) begin
      e0 = exp_q.pop_front();
      e1 = exp_c_q.pop_front();
      checks++;
      assert (obs0 === e0) else begin
        errors++; $error("FAIL %s observed %h expected %h", tag, obs0, e0);
      end
      checks++;
      assert (obs1 === e1) else begin
        errors++; $error("FAIL %s_c observed %h expected %h", tag, obs1, e1);
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    logic [42:0] redir_tv, redir_mepc;
    redir_tv   = mk(0, 0, 5'd0, 1, 1, 32'h200, 0, 1);
    redir_mepc = mk(0, 0, 5'd0, 1, 1, 32'h104, 0, 1);
    rst_n_i = 1'b0;
    clear_in();
    csr0.mtvec_i = 32'h200; csr1.mtvec_i = 32'h200;
    csr0.mepc_i  = 32'h104; csr1.mepc_i  = 32'h104;
    repeat (2) @(negedge clk_i);

    push2(Z, Z); cyc("reset");
    rst_n_i = 1'b1;
    push2(Z, Z); cyc("post_reset");

    // ID ecall; ecall held during redirect must be ignored
    id_valid_i = 1; id_ecall_i = 1;
    push2(mk(1, 0, 5'd11, 1, 0, 0, 0, 0), mk(1, 0, 5'd11, 1, 0, 0, 0, 0)); cyc("ecall_n");
    push2(redir_tv, redir_tv); cyc("ecall_redir");
    clear_in();
    push2(Z, Z); cyc("ecall_idle");

    // EX load misaligned beats same-cycle ID illegal
    ex_valid_i = 1; ex_load_misaligned_i = 1; id_valid_i = 1; id_illegal_i = 1;
    push2(mk(0, 1, 5'd4, 1, 0, 0, 0, 0), mk(0, 1, 5'd4, 1, 0, 0, 0, 0)); cyc("ex_over_id");
    clear_in();
    push2(redir_tv, redir_tv); cyc("ex_over_id_redir");
    push2(Z, Z); cyc("ex_over_id_idle");

    // MRET
    id_valid_i = 1; id_mret_i = 1;
    push2(mk(0, 0, 5'd0, 1, 0, 0, 1, 0), mk(0, 0, 5'd0, 1, 0, 0, 1, 0)); cyc("mret_n");
    clear_in();
    push2(redir_mepc, redir_mepc); cyc("mret_redir");
    push2(Z, Z); cyc("mret_idle");

    // ID exception beats MRET; ebreak beats ecall; misaligned beats illegal
    id_valid_i = 1; id_mret_i = 1; id_ecall_i = 1; id_ebreak_i = 1;
    push2(mk(1, 0, 5'd3, 1, 0, 0, 0, 0), mk(1, 0, 5'd3, 1, 0, 0, 0, 0)); cyc("ebreak_over_mret");
    clear_in();
    push2(redir_tv, redir_tv); cyc("ebreak_redir");
    id_valid_i = 1; id_illegal_i = 1; id_instr_misaligned_i = 1;
    push2(mk(1, 0, 5'd0, 1, 0, 0, 0, 0), mk(1, 0, 5'd0, 1, 0, 0, 0, 0)); cyc("id_misaligned");
    clear_in();
    push2(redir_tv, redir_tv); cyc("id_mis_redir");

    // Taken branch to 0x102: traps only without compressed ISA
    ex_valid_i = 1; ex_branch_taken_i = 1; ex_branch_target_i = 32'h102;
    push2(mk(0, 1, 5'd0, 1, 0, 0, 0, 0), Z); cyc("br_102");
    clear_in();
    push2(redir_tv, Z); cyc("br_102_redir");
    ex_valid_i = 1; ex_branch_taken_i = 1; ex_branch_target_i = 32'h100;
    push2(Z, Z); cyc("br_100_ok");
    ex_branch_target_i = 32'h103;
    push2(mk(0, 1, 5'd0, 1, 0, 0, 0, 0), mk(0, 1, 5'd0, 1, 0, 0, 0, 0)); cyc("br_103");
    clear_in();
    push2(redir_tv, redir_tv); cyc("br_103_redir");

    // Branch misaligned beats load; store alone gives 6
    ex_valid_i = 1; ex_branch_taken_i = 1; ex_branch_target_i = 32'h101; ex_load_misaligned_i = 1;
    push2(mk(0, 1, 5'd0, 1, 0, 0, 0, 0), mk(0, 1, 5'd0, 1, 0, 0, 0, 0)); cyc("br_over_load");
    clear_in();
    push2(redir_tv, redir_tv); cyc("br_over_load_redir");
    ex_valid_i = 1; ex_store_misaligned_i = 1;
    push2(mk(0, 1, 5'd6, 1, 0, 0, 0, 0), mk(0, 1, 5'd6, 1, 0, 0, 0, 0)); cyc("store");
    clear_in();
    push2(redir_tv, redir_tv); cyc("store_redir");
    ex_store_misaligned_i = 1; ex_load_misaligned_i = 1;
    push2(Z, Z); cyc("ex_not_valid");
    clear_in();

    // Stalled ID illegal held off for 3 cycles
    id_valid_i = 1; id_illegal_i = 1; id_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      push2(Z, Z); cyc("stall_hold");
    end
    id_stall_i = 0;
    push2(mk(1, 0, 5'd2, 1, 0, 0, 0, 0), mk(1, 0, 5'd2, 1, 0, 0, 0, 0)); cyc("stall_drop");
    id_illegal_i = 0; id_ecall_i = 1;
    push2(redir_tv, redir_tv); cyc("ecall_in_redir");
    clear_in();
    push2(Z, Z); cyc("stall_idle");

    // EX exception accepted while ID is stalled
    id_valid_i = 1; id_illegal_i = 1; id_stall_i = 1; ex_valid_i = 1; ex_store_misaligned_i = 1;
    push2(mk(0, 1, 5'd6, 1, 0, 0, 0, 0), mk(0, 1, 5'd6, 1, 0, 0, 0, 0)); cyc("ex_during_stall");
    clear_in();
    push2(redir_tv, redir_tv); cyc("ex_stall_redir");

    // Reset asserted mid-TRAP_REDIR
    id_valid_i = 1; id_ecall_i = 1;
    push2(mk(1, 0, 5'd11, 1, 0, 0, 0, 0), mk(1, 0, 5'd11, 1, 0, 0, 0, 0)); cyc("rst_pre");
    clear_in();
    rst_n_i = 1'b0;
    push2(Z, Z); cyc("rst_mid_redir");
    rst_n_i = 1'b1;
    push2(Z, Z); cyc("rst_release");
    push2(Z, Z); cyc("rst_no_pcset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Initiator side of the CSR file's trap-handling interface. Collects exception requests from the ID and EX stages and MRET from ID, and chooses one per cycle. It drives save_pc_id/save_pc_ex and exception_cause into the CSR file, flushes the pipeline, and then redirects fetch to mtvec (trap) or mepc (MRET). It sits in the core controller, between the ID/EX stages, the CSR file and the PC-select logic in IF.

Parameters:
ISA_C, 0, compressed ISA enabled; when 1, a taken branch/jump target only needs 2-byte alignment
ISA_M, 0, passed through for consistency with the CSR file; no functional effect in this block

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous, active-low reset
id_valid_i  in  1  ID holds a valid instruction
id_stall_i  in  1  ID is stalled this cycle
id_instr_misaligned_i  in  1  fetch address misaligned
id_illegal_i  in  1  illegal instruction decoded
id_ebreak_i  in  1  EBREAK decoded
id_ecall_i  in  1  ECALL decoded
id_mret_i  in  1  MRET decoded
ex_valid_i  in  1  EX holds a valid instruction
ex_load_misaligned_i  in  1  load address misaligned
ex_store_misaligned_i  in  1  store address misaligned
ex_branch_taken_i  in  1  branch/jump taken in EX
ex_branch_target_i  in  32  target of that branch/jump
mtvec_i  in  32  from CSR mtvec_o
mepc_i  in  32  from CSR mepc_o (next-value form)
save_pc_id_o  out  1  to CSR: write ID PC into mepc
save_pc_ex_o  out  1  to CSR: write EX PC into mepc
exception_cause_o  out  5  to CSR: mcause code
flush_o  out  1  kill IF, ID, EX this cycle
pc_set_o  out  1  fetch redirect strobe
pc_target_o  out  32  redirect address
mret_o  out  1  one-cycle pulse, MRET committed
busy_o  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, TRAP_REDIR, MRET_REDIR. Encoded as a 2-bit state; the registered state is the only state in the block.
- Reset: state=IDLE. All outputs are 0, and pc_target_o=0.
- EX trap condition, checked in IDLE only and qualified by ex_valid_i:
  - load misaligned gives cause 4; store misaligned gives cause 6.
  - Branch-target misaligned gives cause 0. It fires when ex_branch_taken_i is set and target[1:0]!=0 (ISA_C=0) or target[0]!=0 (ISA_C=1).
  - Priority among EX causes: 0 > 4 > 6.
- ID trap condition, checked in IDLE only and qualified by id_valid_i && !id_stall_i.
  - Priority: misaligned (0) > illegal (2) > ebreak (3) > ecall (11).
- Arbitration in IDLE, applied combinationally in the same cycle:
  - An EX trap wins (older instruction). It drives save_pc_ex_o=1, the EX cause, and flush_o=1; next state is TRAP_REDIR. ID requests and MRET are ignored that cycle.
  - Otherwise an ID trap drives save_pc_id_o=1, the ID cause, and flush_o=1; next state is TRAP_REDIR. An ID exception beats MRET.
  - Otherwise id_mret_i (qualified like ID) drives flush_o=1 and mret_o=1; next state is MRET_REDIR.
- save_pc_id_o and save_pc_ex_o are mutually exclusive and never both 1. This is required by the CSR file's unique case.
- exception_cause_o is 0 whenever neither save strobe is asserted.
- TRAP_REDIR, one cycle: pc_set_o=1, pc_target_o=mtvec_i (direct mode, low 8 bits already zero), flush_o=1; next state IDLE.
- MRET_REDIR, one cycle: pc_set_o=1, pc_target_o=mepc_i, flush_o=1; next state IDLE.
- Latency: request cycle N sees save/flush in N, redirect in N+1, and a new request is accepted from N+2.
- busy_o=1 in TRAP_REDIR and MRET_REDIR. All exception/MRET inputs are ignored there, because the flushed stages are invalid.
- Stalled ID: the exception is held off until id_stall_i drops. EX exceptions are still accepted during an ID stall.
- Reset mid-redirect returns to IDLE with no pc_set_o.

Decomposition:
- core_pkg gains exc_cause_t: a 5-bit enum EXC_INSTR_MISALIGNED=0, EXC_ILLEGAL_INSTR=2, EXC_BREAKPOINT=3, EXC_LOAD_MISALIGNED=4, EXC_STORE_MISALIGNED=6, EXC_ECALL_M=11.
- core_pkg also gains trap_state_t for the FSM.
- One natural sub-module, exc_prio_enc: a combinational priority encoder instantiated twice (ID, EX), giving valid plus cause from a request vector.

Test Plan:
1. Reset asserted mid-TRAP_REDIR -> all outputs 0 immediately; after release the FSM is IDLE and pc_set_o is never seen.
2. ID ecall, mtvec_i=0x00000200, id_valid_i=1 -> cycle N: save_pc_id_o=1, cause=11, flush_o=1; N+1: pc_set_o=1, pc_target_o=0x200; N+2: busy_o=0.
3. Same-cycle EX load misaligned and ID illegal -> only save_pc_ex_o=1, cause=4; the ID request is dropped and never raised later.
4. ID MRET with mepc_i=0x00000104 -> N: flush_o=1, mret_o=1, no save strobe; N+1: pc_set_o=1, pc_target_o=0x104.
5. Taken branch to 0x00000102:
   - ISA_C=0 -> save_pc_ex_o=1, cause=0.
   - ISA_C=1 -> no trap.
   - Target 0x103 with ISA_C=1 -> cause 0.
6. ID illegal with id_stall_i=1 for 3 cycles -> no strobes; trap is taken the cycle the stall drops. An ecall presented during TRAP_REDIR is ignored.
